prog_mem_loader: RTL and testbench
==================================

// Module: prog_mem_loader
// PURPOSE
//  Program memory responder for the CPU instruction fetch bus: serves data_bus = mem[addr_bus] every cycle.
//  Includes an SPI-slave loader that writes/reads back the 1 KiB program image.
//  Controls cpu_rst, holding the CPU in reset until the host issues RUN.
//  Sits between the external host/flash SPI pins and the cpuy fetch port.
// PARAMETERS
//  ADDR_W       10    fetch/loader address width
//  DEPTH        1024  program memory bytes (2**ADDR_W)
//  SYNC_STAGES  2     synchroniser flops on spi_sclk/spi_cs_n/spi_mosi
// PORTS
//  clk          in   1       system clock, same clock as the CPU
//  rst          in   1       reset; synchronous, active-high
//  spi_sclk     in   1       SPI clock, mode 0, max clk/4
//  spi_cs_n     in   1       SPI chip select, active-low
//  spi_mosi     in   1       SPI data in, MSB first
//  spi_miso     out  1       SPI data out, MSB first
//  addr_bus     in   ADDR_W  CPU fetch address (CPU pc)
//  data_bus     out  8       fetched byte, combinational mem[addr_bus]
//  cpu_rst      out  1       CPU reset, active-high
//  busy         out  1       high while cs_n is low (transaction open)
//  err          out  1       sticky: WRITE attempted while CPU running, or unknown command
// BEHAVIOUR
//  Reset: cpu_rst=1, busy=0, err=0, spi_miso=0, FSM=IDLE, bit count 0, load addr 0.
//    Memory contents are not reset.
//  Fetch port: asynchronous read, zero latency. The CPU samples data_bus on the edge after it drives pc,
//    so a registered read is forbidden.
//  SPI front end: SYNC_STAGES-flop sync; sclk rise/fall detected in clk domain.
//    Rising edge shifts mosi in; falling edge shifts the miso register out.
//  Byte done on 8th rising edge. cs_n high at any time -> FSM=IDLE, partial byte discarded, busy=0.
//  FSM states and transitions on each completed byte:
//    IDLE  -> CMD on cs_n fall.
//    CMD:  0x02 -> ADDR_H (write); 0x03 -> ADDR_H (read).
//          0x55 RUN: cpu_rst<=0 -> IGNORE.  0xAA HALT: cpu_rst<=1 -> IGNORE.
//          any other value: err<=1 -> IGNORE.
//    ADDR_H: addr[9:8] <= byte[1:0]; byte[7:2] ignored.
//    ADDR_L: addr[7:0] <= byte.
//      Write: -> WR_DATA.
//      Read:  load miso shift reg with mem[addr], drive MSB -> RD_DATA.
//    WR_DATA: mem[addr] <= byte (one clk write), addr++.
//      If cpu_rst==0: no write, err<=1, addr still increments.
//    RD_DATA: after each 8 falling edges, addr++, reload shift reg with mem[addr].
//    IGNORE: absorbs bytes until cs_n high.
//  Address wraps 1023 -> 0 in both WR_DATA and RD_DATA.
//  Simultaneous CPU fetch and loader write to the same address: data_bus shows the old byte
//    until the write edge, the new byte after it.
//  RUN while already running and HALT while halted: no effect, no error.
//  err clears only on rst.
//  rst mid-transaction: FSM=IDLE and cpu_rst=1. A host byte in flight is lost; the host
//    must toggle cs_n before the next command.
//  spi_miso = 0 outside RD_DATA.
// STRUCTURE
//  Shared package (cpu_pkg): LDR_CMD_WRITE=8'h02, LDR_CMD_READ=8'h03, LDR_CMD_RUN=8'h55,
//    LDR_CMD_HALT=8'hAA, loader FSM state encoding, RESET_VECTOR.
//  One sub-module: spi_slave_shifter (sync, edge detect, 8-bit shift in/out, byte_valid, load strobe).
//  FSM, address counter, memory array and cpu_rst live in prog_mem_loader.
// TESTING
//  1. rst, no SPI -> cpu_rst=1, busy=0, err=0, spi_miso=0.
//  2. WRITE 02 00 00 3D A5 -> mem[0]=8'h3D, mem[1]=8'hA5.
//     addr_bus=1 -> data_bus=8'hA5 in the same cycle.
//  3. WRITE 02 03 FF 11 22 -> mem[1023]=8'h11, mem[0]=8'h22 (wrap).
//     READ 03 03 FF + 16 clocks -> miso 8'h11 then 8'h22.
//  4. RUN 55 -> cpu_rst falls after the 8th bit. Then WRITE 02 00 05 77 -> mem[5] unchanged, err=1.
//     HALT AA -> cpu_rst=1.
//  5. cs_n raised after 4 bits of a data byte -> no write, FSM=IDLE.
//     Next WRITE 02 00 10 99 -> mem[16]=8'h99.
//  6. Command 8'h7E -> err=1, subsequent bytes ignored.
//     rst asserted mid-READ -> spi_miso=0, cpu_rst=1, FSM=IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: loader command bytes, loader FSM encoding, reset vector.
package cpu_pkg;
    localparam logic [7:0] LDR_CMD_WRITE = 8'h02;
    localparam logic [7:0] LDR_CMD_READ  = 8'h03;
    localparam logic [7:0] LDR_CMD_RUN   = 8'h55;
    localparam logic [7:0] LDR_CMD_HALT  = 8'hAA;

    localparam int unsigned RESET_VECTOR = 0;

    typedef enum logic [2:0] {
        LDR_IDLE,
        LDR_CMD,
        LDR_ADDR_H,
        LDR_ADDR_L,
        LDR_WR_DATA,
        LDR_RD_DATA,
        LDR_IGNORE
    } ldr_state_t;
endpackage

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave front end: input synchronisers, sclk/cs edge detect,
// 8-bit receive shifter with byte_valid, 8-bit transmit shifter with load strobe.
module spi_slave_shifter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic       cs_active,
    output logic       cs_fall,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       tx_done,
    output logic       tx_bit
);
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, vld_pipe;
    logic       sclk_s, cs_s, mosi_s, sclk_prev, cs_prev, armed;
    logic       rise, fall;
    logic [2:0] bit_cnt, tx_cnt;
    logic [7:0] rx_sr, tx_sr;
    logic       tx_skip;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_prev;
    assign fall   = ~sclk_s & sclk_prev;

    // cs_fall only counts once a real (post-reset) high has been seen on cs,
    // so a reset in the middle of a transaction cannot fake a new command.
    assign cs_active  = ~cs_s;
    assign cs_fall    = armed & cs_prev & ~cs_s;
    assign byte_valid = cs_active & rise & (bit_cnt == 3'd7);
    assign rx_byte    = {rx_sr[6:0], mosi_s};
    assign tx_done    = cs_active & fall & ~tx_skip & (tx_cnt == 3'd7);
    assign tx_bit     = tx_sr[7];

    // Synchronisers, edge history and the cs arming flag
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            vld_pipe  <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            vld_pipe  <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            armed     <= armed | (vld_pipe[SYNC_STAGES-1] & cs_s);
        end
    end

    // Receive shifter: sample mosi on sclk rise; cs high drops a partial byte
    always_ff @(posedge clk) begin
        if (rst || !cs_active) begin
            bit_cnt <= '0;
            rx_sr   <= '0;
        end else if (rise) begin
            rx_sr   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Transmit shifter: shift on sclk fall; a load made on a rise skips the
    // trailing fall of that same byte so the MSB is held for the next byte
    always_ff @(posedge clk) begin
        if (rst || !cs_active) begin
            tx_sr   <= '0;
            tx_cnt  <= '0;
            tx_skip <= 1'b0;
        end else if (load) begin
            tx_sr   <= load_data;
            tx_cnt  <= '0;
            tx_skip <= rise;
        end else if (fall) begin
            if (tx_skip) begin
                tx_skip <= 1'b0;
            end else begin
                tx_sr  <= {tx_sr[6:0], 1'b0};
                tx_cnt <= tx_cnt + 3'd1;
            end
        end
    end
endmodule

// File: rtl/prog_mem_loader.sv
// Program memory with zero-latency fetch port, SPI loader FSM and CPU reset control.
module prog_mem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic [ADDR_W-1:0] addr_bus,
    output logic [7:0]        data_bus,
    output logic              cpu_rst,
    output logic              busy,
    output logic              err
);
    logic [7:0]        mem [DEPTH];
    ldr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] addr, ld_addr;
    logic              rd_mode;
    logic              cs_active, cs_fall, byte_valid, tx_done, tx_bit;
    logic [7:0]        rx_byte;
    logic              wr_en, ld, do_run, do_halt, do_err, set_mode, mode_val;
    logic              ld_hi, ld_lo, inc;

    spi_slave_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .load       (ld),
        .load_data  (mem[ld_addr]),
        .cs_active  (cs_active),
        .cs_fall    (cs_fall),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .tx_done    (tx_done),
        .tx_bit     (tx_bit)
    );

    assign data_bus = mem[addr_bus];
    assign busy     = cs_active;
    assign spi_miso = (state == LDR_RD_DATA) & tx_bit;

    // Loader FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= LDR_IDLE;
        else     state <= state_nxt;
    end

    // Next state and per-byte action strobes
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        ld        = 1'b0;
        ld_addr   = addr;
        do_run    = 1'b0;
        do_halt   = 1'b0;
        do_err    = 1'b0;
        set_mode  = 1'b0;
        mode_val  = 1'b0;
        ld_hi     = 1'b0;
        ld_lo     = 1'b0;
        inc       = 1'b0;
        if (!cs_active) begin
            state_nxt = LDR_IDLE;
        end else begin
            case (state)
                LDR_IDLE:    if (cs_fall) state_nxt = LDR_CMD;
                LDR_CMD: if (byte_valid) begin
                    case (rx_byte)
                        LDR_CMD_WRITE: begin set_mode = 1'b1; mode_val = 1'b0; state_nxt = LDR_ADDR_H; end
                        LDR_CMD_READ:  begin set_mode = 1'b1; mode_val = 1'b1; state_nxt = LDR_ADDR_H; end
                        LDR_CMD_RUN:   begin do_run  = 1'b1; state_nxt = LDR_IGNORE; end
                        LDR_CMD_HALT:  begin do_halt = 1'b1; state_nxt = LDR_IGNORE; end
                        default:       begin do_err  = 1'b1; state_nxt = LDR_IGNORE; end
                    endcase
                end
                LDR_ADDR_H: if (byte_valid) begin
                    ld_hi     = 1'b1;
                    state_nxt = LDR_ADDR_L;
                end
                LDR_ADDR_L: if (byte_valid) begin
                    ld_lo = 1'b1;
                    if (rd_mode) begin
                        ld        = 1'b1;
                        ld_addr   = {addr[ADDR_W-1:8], rx_byte};
                        state_nxt = LDR_RD_DATA;
                    end else begin
                        state_nxt = LDR_WR_DATA;
                    end
                end
                LDR_WR_DATA: if (byte_valid) begin
                    inc = 1'b1;
                    if (cpu_rst) wr_en  = 1'b1;
                    else         do_err = 1'b1;
                end
                LDR_RD_DATA: if (tx_done) begin
                    inc     = 1'b1;
                    ld      = 1'b1;
                    ld_addr = addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Address counter, read/write mode, CPU reset and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            addr    <= ADDR_W'(RESET_VECTOR);
            rd_mode <= 1'b0;
            cpu_rst <= 1'b1;
            err     <= 1'b0;
        end else begin
            if (set_mode) rd_mode <= mode_val;
            if (do_run)   cpu_rst <= 1'b0;
            if (do_halt)  cpu_rst <= 1'b1;
            if (do_err)   err     <= 1'b1;
            if (ld_hi)    addr[ADDR_W-1:8] <= rx_byte[ADDR_W-9:0];
            if (ld_lo)    addr[7:0] <= rx_byte;
            if (inc)      addr <= addr + ADDR_W'(1);
        end
    end

    // Loader write port; memory contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= rx_byte;
    end
endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: SPI host model driving load/read/run/halt traffic.
module tb_prog_mem_loader;
    localparam int HALF = 6;   // sclk half period in clk cycles (sclk = clk/12)

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic [9:0] addr_bus = '0;
    logic       spi_miso, cpu_rst, busy, err;
    logic [7:0] data_bus;
    logic [7:0] r;
    int         checks = 0;
    int         errors = 0;

    prog_mem_loader dut (
        .clk      (clk),
        .rst      (rst),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .addr_bus (addr_bus),
        .data_bus (data_bus),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_mem(input string tag, input logic [9:0] a, input logic [7:0] exp);
        addr_bus = a;
        #1;
        chk(tag, {8'h00, data_bus}, {8'h00, exp});
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_end();
        wait_clk(HALF);
        spi_cs_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    // Shift n bits of tx out MSB first, capturing miso just before each rising edge
    task automatic spi_xfer(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = tx[i];
            wait_clk(HALF);
            rx[i] = spi_miso;
            spi_sclk = 1'b1;
            wait_clk(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] tx);
        logic [7:0] dummy;
        spi_xfer(tx, 8, dummy);
    endtask

    task automatic txn(input int n, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        cs_begin();
        if (n > 0) send(b0);
        if (n > 1) send(b1);
        if (n > 2) send(b2);
        if (n > 3) send(b3);
        if (n > 4) send(b4);
        cs_end();
    endtask

    initial begin
        // 1. reset state
        wait_clk(4);
        rst = 1'b0;
        wait_clk(4);
        chk("rst_cpu_rst", {15'd0, cpu_rst}, 16'd1);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_miso", {15'd0, spi_miso}, 16'd0);

        // 2. write two bytes, fetch port sees them with zero latency
        cs_begin();
        chk("busy_open", {15'd0, busy}, 16'd1);
        send(8'h02); send(8'h00); send(8'h00); send(8'h3D); send(8'hA5);
        cs_end();
        chk("busy_closed", {15'd0, busy}, 16'd0);
        chk_mem("mem0_3d", 10'd0, 8'h3D);
        chk_mem("mem1_a5", 10'd1, 8'hA5);
        txn(4, 8'h02, 8'h00, 8'h05, 8'h5C, 8'h00);
        txn(4, 8'h02, 8'h00, 8'h10, 8'hE1, 8'h00);
        txn(4, 8'h02, 8'h00, 8'h20, 8'h4B, 8'h00);
        chk_mem("mem5_5c", 10'd5, 8'h5C);

        // 3. write across the top of memory, then read it back over the wrap
        txn(5, 8'h02, 8'h03, 8'hFF, 8'h11, 8'h22);
        chk_mem("mem1023_11", 10'd1023, 8'h11);
        chk_mem("mem0_wrap_22", 10'd0, 8'h22);
        cs_begin();
        send(8'h03); send(8'h03); send(8'hFF);
        spi_xfer(8'h00, 8, r);
        chk("rd_byte0", {8'h00, r}, 16'h0011);
        spi_xfer(8'h00, 8, r);
        chk("rd_byte1_wrap", {8'h00, r}, 16'h0022);
        cs_end();
        chk("miso_idle", {15'd0, spi_miso}, 16'd0);

        // 4. RUN, repeated RUN, blocked write, HALT
        cs_begin();
        chk("pre_run_cpu_rst", {15'd0, cpu_rst}, 16'd1);
        send(8'h55);
        wait_clk(2);
        chk("run_cpu_rst", {15'd0, cpu_rst}, 16'd0);
        cs_end();
        txn(1, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("rerun_cpu_rst", {15'd0, cpu_rst}, 16'd0);
        chk("rerun_err", {15'd0, err}, 16'd0);
        txn(4, 8'h02, 8'h00, 8'h05, 8'h77, 8'h00);
        chk_mem("mem5_kept", 10'd5, 8'h5C);
        chk("wr_running_err", {15'd0, err}, 16'd1);
        txn(1, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("halt_cpu_rst", {15'd0, cpu_rst}, 16'd1);
        txn(1, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("rehalt_cpu_rst", {15'd0, cpu_rst}, 16'd1);

        // 5. partial data byte is discarded, next transaction works
        cs_begin();
        send(8'h02); send(8'h00); send(8'h10);
        spi_xfer(8'h33, 4, r);
        cs_end();
        chk("partial_busy", {15'd0, busy}, 16'd0);
        chk_mem("mem16_kept", 10'd16, 8'hE1);
        txn(4, 8'h02, 8'h00, 8'h10, 8'h99, 8'h00);
        chk_mem("mem16_99", 10'd16, 8'h99);

        // 6a. reset clears err; reset mid-READ drops the transaction
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(4);
        chk("rst2_err", {15'd0, err}, 16'd0);
        txn(1, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("run2_cpu_rst", {15'd0, cpu_rst}, 16'd0);
        cs_begin();
        send(8'h03); send(8'h00); send(8'h01);
        chk("rd_msb_a5", {15'd0, spi_miso}, 16'd1);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        #1;
        chk("midrd_miso", {15'd0, spi_miso}, 16'd0);
        chk("midrd_cpu_rst", {15'd0, cpu_rst}, 16'd1);
        wait_clk(4);
        send(8'h7E);
        wait_clk(2);
        chk("no_toggle_ignored", {15'd0, err}, 16'd0);
        cs_end();

        // 6b. unknown command sets err and swallows the rest of the transaction
        txn(5, 8'h7E, 8'h02, 8'h00, 8'h20, 8'h66);
        chk("badcmd_err", {15'd0, err}, 16'd1);
        chk_mem("mem32_kept", 10'd32, 8'h4B);
        cs_begin();
        send(8'h03); send(8'h03); send(8'hFF);
        spi_xfer(8'h00, 8, r);
        chk("recover_rd", {8'h00, r}, 16'h0011);
        cs_end();
        chk("err_sticky", {15'd0, err}, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
